// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, RTS, device-clocked 11-bit frame, ack check; busy strobes are dropped.
// Optional macro PS2_HOST_TX_RETRY_EN: a NACK/timeout retries the latched byte up to twice before tx_err_o pulses.
module ps2_host_tx #(
   parameter int INHIBIT_CYCLES      = 2500,
   parameter int RTS_TIMEOUT_CYCLES  = 375000,
   parameter int XFER_TIMEOUT_CYCLES = 50000
) (
   input  logic       clk_i,
   input  logic       rst_n,
   input  logic [7:0] tx_data_i,
   input  logic       tx_data_en_i,
   output logic       tx_ready_o,
   output logic       tx_done_o,
   output logic       tx_err_o,
   input  logic       ps2_clk_i,
   input  logic       ps2_dat_i,
   output logic       ps2_clk_oe_o,
   output logic       ps2_dat_oe_o
);

   localparam int CNT_MAX_A = (INHIBIT_CYCLES > RTS_TIMEOUT_CYCLES) ? INHIBIT_CYCLES : RTS_TIMEOUT_CYCLES;
   localparam int CNT_MAX   = (CNT_MAX_A > XFER_TIMEOUT_CYCLES) ? CNT_MAX_A : XFER_TIMEOUT_CYCLES;
   localparam int CNT_W     = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] INH_LAST  = CNT_W'(INHIBIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] RTS_LAST  = CNT_W'(RTS_TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] XFER_LAST = CNT_W'(XFER_TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_INHIBIT,
      S_RTS,
      S_SHIFT,
      S_ACK,
      S_WAIT_IDLE,
      S_ERR
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic             r_clk_s1;
   logic             r_clk_s2;
   logic             r_clk_d1;
   logic             r_dat_s1;
   logic             r_dat_s2;
   logic [8:0]       r_frame;
   logic [8:0]       r_shift;
   logic [3:0]       r_bit_cnt;
   logic [3:0]       w_bit_cnt_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic             w_cnt_clr;
   logic             w_fall;
   logic             w_accept;
   logic             w_fail;
   logic             w_load;
   logic             w_shift;
`ifdef PS2_HOST_TX_RETRY_EN
   logic [1:0]       r_retry;
`endif

   // Pads are asynchronous; sync flops idle high so reset release never looks like an edge.
   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         r_clk_s1 <= 1'b1;
         r_clk_s2 <= 1'b1;
         r_clk_d1 <= 1'b1;
         r_dat_s1 <= 1'b1;
         r_dat_s2 <= 1'b1;
      end else begin
         r_clk_s1 <= ps2_clk_i;
         r_clk_s2 <= r_clk_s1;
         r_clk_d1 <= r_clk_s2;
         r_dat_s1 <= ps2_dat_i;
         r_dat_s2 <= r_dat_s1;
      end
   end

   assign w_fall   = r_clk_d1 & ~r_clk_s2;
   assign w_accept = tx_data_en_i & (r_state == S_IDLE);
   assign w_load   = (r_state == S_RTS) & w_fall;
   assign w_shift  = (r_state == S_SHIFT) & w_fall;

   always_comb begin
      w_state_nxt   = r_state;
      w_bit_cnt_nxt = r_bit_cnt;
      w_cnt_clr     = 1'b0;
      w_fail        = 1'b0;
      tx_done_o     = 1'b0;
      tx_err_o      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_state_nxt = S_INHIBIT;
               w_cnt_clr   = 1'b1;
            end
         end
         S_INHIBIT: begin
            if (r_cnt >= INH_LAST) begin
               w_state_nxt = S_RTS;
               w_cnt_clr   = 1'b1;
            end
         end
         S_RTS: begin
            // The first device edge also restarts the counter as the transfer timer.
            if (w_fall) begin
               w_state_nxt   = S_SHIFT;
               w_bit_cnt_nxt = 4'd1;
               w_cnt_clr     = 1'b1;
            end else if (r_cnt >= RTS_LAST) begin
               w_fail = 1'b1;
            end
         end
         S_SHIFT: begin
            if (w_fall) begin
               if (r_bit_cnt == 4'd9) begin
                  w_state_nxt = S_ACK;
               end else begin
                  w_bit_cnt_nxt = r_bit_cnt + 4'd1;
               end
            end else if (r_cnt >= XFER_LAST) begin
               w_fail = 1'b1;
            end
         end
         S_ACK: begin
            if (w_fall) begin
               if (r_dat_s2) begin
                  w_fail = 1'b1;
               end else begin
                  w_state_nxt = S_WAIT_IDLE;
               end
            end else if (r_cnt >= XFER_LAST) begin
               w_fail = 1'b1;
            end
         end
         S_WAIT_IDLE: begin
            if (r_clk_s2 & r_dat_s2) begin
               tx_done_o   = 1'b1;
               w_state_nxt = S_IDLE;
            end else if (r_cnt >= XFER_LAST) begin
               w_fail = 1'b1;
            end
         end
         S_ERR: begin
            tx_err_o    = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase

      if (w_fail) begin
`ifdef PS2_HOST_TX_RETRY_EN
         if (r_retry < 2'd2) begin
            w_state_nxt = S_INHIBIT;
            w_cnt_clr   = 1'b1;
         end else begin
            w_state_nxt = S_ERR;
         end
`else
         w_state_nxt = S_ERR;
`endif
      end
   end

   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_bit_cnt <= 4'd0;
         r_cnt     <= '0;
         r_frame   <= 9'h1FF;
         r_shift   <= 9'h1FF;
      end else begin
         r_state   <= w_state_nxt;
         r_bit_cnt <= w_bit_cnt_nxt;
         if (w_cnt_clr || (r_state == S_IDLE)) begin
            r_cnt <= '0;
         end else if (r_cnt != '1) begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
         if (w_accept) begin
            r_frame <= {~^tx_data_i, tx_data_i};
         end
         // Frame bits leave LSB first; the refill with 1s is the released stop level.
         if (w_load) begin
            r_shift <= r_frame;
         end else if (w_shift) begin
            r_shift <= {1'b1, r_shift[8:1]};
         end
      end
   end

`ifdef PS2_HOST_TX_RETRY_EN
   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         r_retry <= 2'd0;
      end else if (w_accept) begin
         r_retry <= 2'd0;
      end else if (w_fail && (r_retry < 2'd2)) begin
         r_retry <= r_retry + 2'd1;
      end
   end
`endif

   assign tx_ready_o   = (r_state == S_IDLE);
   assign ps2_clk_oe_o = (r_state == S_INHIBIT);
   assign ps2_dat_oe_o = (r_state == S_RTS) | ((r_state == S_SHIFT) & ~r_shift[0]);

endmodule
